// File: rtl/demux_pkg.sv
// Shared types and helpers for the demux_router slice: slot states, parameter defaults and
// packed-bus indexing.
package demux_pkg;

    localparam int unsigned CNT_W_DEFAULT = 8;

    typedef enum logic [0:0] {
        StEmpty,
        StFull
    } slot_state_e;

    function automatic int unsigned sel_width(input int unsigned channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int unsigned slice(input int unsigned k, input int unsigned width);
        return k * width;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register with valid/ready handshake. A load in the same cycle as a
// drain refills the slot without a bubble.
module demux_slot
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             free
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StEmpty;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        unique case (state_q)
            StEmpty: begin
                if (load) begin
                    state_d = StFull;
                    data_d  = load_data;
                end
            end
            StFull: begin
                if (load) begin
                    data_d = load_data;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
        endcase
    end

    assign out_valid = (state_q == StFull);
    assign out_data  = data_q;
    assign free      = (state_q == StEmpty) | out_ready;

endmodule

// File: rtl/demux_router.sv
// Registered 1-to-N demultiplexer with per-channel holding slots, all-or-nothing broadcast and a
// saturating counter of words dropped for an out-of-range select.
module demux_router
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SEL_W    = sel_width(CHANNELS),
    parameter int unsigned CNT_W    = CNT_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [WIDTH-1:0]          In,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEL_W-1:0]          Sel_DeMux,
    input  logic                      Broadcast,
    input  logic                      Enable,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CNT_W-1:0]          drop_count
);

    logic [CHANNELS-1:0] sel_hit;
    logic [CHANNELS-1:0] free;
    logic [CHANNELS-1:0] load;
    logic                sel_in_range;
    logic                accept;
    logic                drop;
    logic [CNT_W-1:0]    drop_q, drop_d;

    // Decoding by equality keeps the range check valid for non-power-of-two channel counts.
    always_comb begin
        sel_hit = '0;
        for (int unsigned k = 0; k < CHANNELS; k++) begin
            sel_hit[k] = (Sel_DeMux == SEL_W'(k));
        end
    end

    assign sel_in_range = |sel_hit;

    always_comb begin
        in_ready = 1'b0;
        if (Enable && !rst) begin
            if (Broadcast) begin
                in_ready = &free;
            end else if (sel_in_range) begin
                in_ready = |(sel_hit & free);
            end else begin
                in_ready = 1'b1;
            end
        end
    end

    assign accept = in_valid & in_ready;
    assign load   = accept ? (Broadcast ? {CHANNELS{1'b1}} : sel_hit) : '0;
    assign drop   = accept & ~Broadcast & ~sel_in_range;

    always_comb begin
        drop_d = drop_q;
        if (drop && (drop_q != {CNT_W{1'b1}})) begin
            drop_d = drop_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else begin
            drop_q <= drop_d;
        end
    end

    assign drop_count = drop_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_slot
        demux_slot #(
            .WIDTH(WIDTH)
        ) u_slot (
            .clk      (clk),
            .rst      (rst),
            .load     (load[k]),
            .load_data(In),
            .out_ready(out_ready[k]),
            .out_valid(out_valid[k]),
            .out_data (out_data[slice(k, WIDTH) +: WIDTH]),
            .free     (free[k])
        );
    end

endmodule

// File: tb/tb_demux_router.sv
// Scoreboard bench for demux_router: a 4-channel instance under directed and random traffic, and
// a 3-channel instance for out-of-range drops and counter saturation.
module tb_demux_router;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  in_data = 4'h0;
    logic        in_valid = 1'b0;
    logic        bcast = 1'b0;
    logic        enable = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [3:0]  out_ready = 4'h0;
    logic        in_ready;
    logic [15:0] out_data;
    logic [3:0]  out_valid;
    logic [7:0]  drop_count;

    logic        in_valid3 = 1'b0;
    logic        enable3 = 1'b0;
    logic        bcast3 = 1'b0;
    logic [1:0]  sel3 = 2'd0;
    logic [2:0]  out_ready3 = 3'h0;
    logic        in_ready3;
    logic [11:0] out_data3;
    logic [2:0]  out_valid3;
    logic [7:0]  drop_count3;

    int checks = 0;
    int errors = 0;
    logic mon_en = 1'b0;

    // Words accepted per channel and not yet taken by the consumer; depth never exceeds one.
    logic [3:0] exp_q [4][$];

    always #5 clk = ~clk;

    demux_router #(
        .WIDTH   (4),
        .CHANNELS(4),
        .CNT_W   (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .In        (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Sel_DeMux (sel),
        .Broadcast (bcast),
        .Enable    (enable),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count)
    );

    demux_router #(
        .WIDTH   (4),
        .CHANNELS(3),
        .CNT_W   (8)
    ) dut3 (
        .clk       (clk),
        .rst       (rst),
        .In        (in_data),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .Sel_DeMux (sel3),
        .Broadcast (bcast3),
        .Enable    (enable3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .drop_count(drop_count3)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: 2 units after the falling edge, before the driver's sample at 3 units.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("out_valid[%0d]", k), 32'(out_valid[k]),
                          32'(exp_q[k].size() != 0));
                    if (exp_q[k].size() != 0) begin
                        check($sformatf("out_data[%0d]", k), 32'(out_data[k*4 +: 4]),
                              32'(exp_q[k][0]));
                        if (out_ready[k]) void'(exp_q[k].pop_front());
                    end
                end
            end
        end
    end

    // One source cycle on the 4-channel instance; the model predicts in_ready from occupancy.
    task automatic step(input logic v, input logic [3:0] d, input logic [1:0] s, input logic b,
                        input logic e, input logic [3:0] r, output logic stall);
        logic exp_rdy;
        @(negedge clk);
        in_valid  = v;
        in_data   = d;
        sel       = s;
        bcast     = b;
        enable    = e;
        out_ready = r;
        #3;
        if (!e) begin
            exp_rdy = 1'b0;
        end else if (b) begin
            exp_rdy = 1'b1;
            for (int k = 0; k < 4; k++) if (exp_q[k].size() != 0) exp_rdy = 1'b0;
        end else begin
            exp_rdy = (exp_q[s].size() == 0);
        end
        check("in_ready", 32'(in_ready), 32'(exp_rdy));
        check("drop_count stays 0", 32'(drop_count), 32'd0);
        if (v && in_ready) begin
            if (b) begin
                for (int k = 0; k < 4; k++) exp_q[k].push_back(d);
            end else begin
                exp_q[s].push_back(d);
            end
        end
        stall = v & ~in_ready;
    endtask

    task automatic do_reset();
        @(negedge clk);
        mon_en    = 1'b0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_valid3 = 1'b1;
        enable    = 1'b1;
        enable3   = 1'b1;
        out_ready = 4'h0;
        #3;
        check("in_ready in reset", 32'(in_ready), 32'd0);
        check("dut3 in_ready in reset", 32'(in_ready3), 32'd0);
        @(negedge clk);
        #3;
        check("out_valid after reset", 32'(out_valid), 32'd0);
        check("out_data after reset", 32'(out_data), 32'd0);
        check("drop_count after reset", 32'(drop_count), 32'd0);
        check("dut3 out_valid after reset", 32'(out_valid3), 32'd0);
        check("dut3 drop_count after reset", 32'(drop_count3), 32'd0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        @(negedge clk);
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_valid3 = 1'b0;
        enable3   = 1'b0;
        mon_en    = 1'b1;
    endtask

    initial begin
        logic       st;
        logic       v, b, e;
        logic [3:0] d, r;
        logic [1:0] s;
        int         n;

        do_reset();
        step(1'b1, 4'h1, 2'd0, 1'b0, 1'b1, 4'hF, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hF, st);

        // Unicast sweep
        for (int i = 0; i < 4; i++) step(1'b1, 4'hA, 2'(i), 1'b0, 1'b1, 4'hF, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hF, st);

        // Back-pressure on channel 2
        step(1'b1, 4'h5, 2'd2, 1'b0, 1'b1, 4'b1011, st);
        for (int i = 0; i < 3; i++) step(1'b1, 4'h6, 2'd2, 1'b0, 1'b1, 4'b1011, st);
        step(1'b1, 4'h6, 2'd2, 1'b0, 1'b1, 4'hF, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hF, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hF, st);

        // Broadcast blocked by a stalled channel 1
        step(1'b1, 4'h3, 2'd1, 1'b0, 1'b1, 4'b1101, st);
        for (int i = 0; i < 3; i++) step(1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 4'b1101, st);
        step(1'b1, 4'hF, 2'd0, 1'b1, 1'b1, 4'hF, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'h0, st);
        step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'h0, st);

        // Enable gating while full slots drain
        for (int i = 0; i < 3; i++) step(1'b1, 4'h9, 2'd0, 1'b0, 1'b0, 4'hF, st);
        step(1'b1, 4'h9, 2'd0, 1'b1, 1'b0, 4'h0, st);

        // Reset with held data discards it
        step(1'b1, 4'h7, 2'd3, 1'b0, 1'b1, 4'h0, st);
        do_reset();

        // Random traffic, honouring the hold rule while stalled
        st = 1'b0;
        v = 1'b0; d = 4'h0; s = 2'd0; b = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (!st) begin
                v = ($urandom_range(0, 3) != 0);
                d = 4'($urandom);
                s = 2'($urandom);
                b = ($urandom_range(0, 7) == 0);
            end
            e = ($urandom_range(0, 7) != 0);
            r = 4'($urandom);
            step(v, d, s, b, e, r, st);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 2'd0, 1'b0, 1'b1, 4'hF, st);

        // Out-of-range drops on the 3-channel instance, through saturation
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid3  = 1'b1;
            sel3       = 2'd3;
            enable3    = 1'b1;
            out_ready3 = 3'($urandom);
            in_data    = 4'($urandom);
            #3;
            check("dut3 in_ready out-of-range", 32'(in_ready3), 32'd1);
            check("dut3 out_valid on drop", 32'(out_valid3), 32'd0);
            check("dut3 drop_count", 32'(drop_count3), 32'((n > 255) ? 255 : n));
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            enable3 = 1'b0;
            #3;
            check("dut3 in_ready disabled", 32'(in_ready3), 32'd0);
            check("dut3 drop_count saturated", 32'(drop_count3), 32'd255);
        end

        // In-range unicast on the 3-channel instance
        @(negedge clk);
        enable3    = 1'b1;
        sel3       = 2'd2;
        in_data    = 4'hC;
        out_ready3 = 3'b000;
        #3;
        check("dut3 in_ready sel 2", 32'(in_ready3), 32'd1);
        @(negedge clk);
        in_valid3 = 1'b0;
        #3;
        check("dut3 out_valid sel 2", 32'(out_valid3), 32'b100);
        check("dut3 out_data sel 2", 32'(out_data3[11:8]), 32'hC);
        check("dut3 drop_count unchanged", 32'(drop_count3), 32'd255);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_router.md
# demux_router

Registered, flow-controlled 1-to-N demultiplexer: the parametrised successor to the fixed 4-way, 4-bit combinational demux. One input stream is steered to one of CHANNELS output ports by a select, or broadcast to all of them. Each output has a one-entry holding register with a valid/ready handshake, so a stalled destination back-pressures the source instead of losing data. It sits between the shared source bus and the per-destination consumers, for example the library, fire department, school and rib shack ports.

## Interface
- WIDTH, 4: data width in bits.
- CHANNELS, 4: number of output channels, ≥2; need not be a power of two.
- SEL_W, $clog2(CHANNELS): select width (derived; do not override).
- CNT_W, 8: width of the drop counter.

- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- In  in  WIDTH  input data.
- in_valid  in  1  input word present.
- in_ready  out  1  input word accepted this cycle when in_valid=1.
- Sel_DeMux  in  SEL_W  destination channel index.
- Broadcast  in  1  1 = deliver to all channels; Sel_DeMux ignored.
- Enable  in  1  0 = accept nothing; outputs still drain.
- out_data  out  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- out_valid  out  CHANNELS  per-channel data valid.
- out_ready  in  CHANNELS  per-channel consumer ready.
- drop_count  out  CNT_W  number of words discarded for an out-of-range select; saturating.

## Operation
- **Slot k state:** valid bit v[k] and data register d[k]. out_valid[k]=v[k]; out_data slice k = d[k].
- **Slot k is "free"** when v[k]=0 or out_ready[k]=1 (it drains in the same cycle).
- **Unicast** (Broadcast=0, Sel_DeMux<CHANNELS):
  - in_ready = Enable & free[Sel_DeMux].
  - On accept: d[Sel]←In and v[Sel]←1.
- **Broadcast** (Broadcast=1):
  - in_ready = Enable & (all slots free).
  - On accept: every d[k]←In and every v[k]←1.
  - Delivery is all-or-nothing; a partial broadcast never occurs.
- **Out-of-range select** (Broadcast=0, Sel_DeMux≥CHANNELS):
  - in_ready = Enable.
  - On accept: the word is discarded and drop_count increments, saturating at 2^CNT_W−1.
- **Drain:** v[k] clears on out_valid[k]&out_ready[k], unless slot k is reloaded in the same cycle, in which case v[k] stays 1 with the new data.
- **Enable=0:** no accept and no drop increment; existing slots still drain normally.
- **Data stability:** d[k] changes only on an accept into slot k. Data is held stable while v[k]=1 and out_ready[k]=0.
- **Per-slot FSM:** EMPTY→FULL on load; FULL→EMPTY on drain without load; FULL→FULL on drain+load or on a stall.

## Timing
- **Reset** (rst=1 at a clock edge):
  - all v[k]=0, all d[k]=0, drop_count=0.
  - in_ready=0 while rst=1.
  - Reset applied mid-transfer discards held data; it has priority over every other event.
- **Latency:** a word accepted in cycle t is on out_data/out_valid from cycle t+1.
- **Throughput:** one word per cycle per channel when the consumer holds out_ready=1 continuously (pass-through refill, no bubble).
- **Combinational paths:** in_ready depends combinationally on Enable, Broadcast, Sel_DeMux and out_ready. There is no combinational path from In to out_data.
- **Source rule:** the source must hold In, Sel_DeMux and Broadcast stable while in_valid=1 and in_ready=0.
- **drop_count** updates the cycle after the discarded accept.

## Structure
- Package demux_pkg:
  - CNT_W default.
  - function sel_width(channels).
  - function slice(k, width) for the packed-bus index.
- Sub-module demux_slot (WIDTH):
  - ports: clk, rst, load, load_data, out_ready, out_valid, out_data, free.
  - instantiated CHANNELS times in a generate loop.
- Top level holds the select decode, the broadcast AND-reduce of free, and the drop counter.

## Test plan
- **Reset:** drive rst=1 with in_valid=1 → all out_valid=0, in_ready=0, drop_count=0; after release, in_ready=1 once Enable=1.
- **Unicast sweep:** CHANNELS=4, send In=0xA with Sel=0..3 in turn, all out_ready=1 → each channel shows 0xA exactly one cycle after accept, and only that channel's out_valid is high.
- **Back-pressure:** out_ready[2]=0, send 0x5 then 0x6 to channel 2 → 0x5 held; in_ready=0 on the second word until out_ready[2]=1, then 0x6 appears the next cycle with no loss or duplicate.
- **Broadcast:** channel 1 stalled full, Broadcast=1, In=0xF → in_ready=0 until channel 1 drains; then all four channels load 0xF in the same cycle.
- **Out-of-range:** CHANNELS=3, Sel=3, send 300 words → no out_valid; drop_count saturates at 255.
- **Enable gating:** Enable=0 with in_valid=1 and full slots draining → in_ready=0, slots empty, no new data loaded.
